// File: rtl/inst_encoder_pkg.sv
// Shared constants, field/comp types and the class-code encoder for inst_encoder.
// The encoder only maps codes; what happens to illegal codes is decided in the top.
package inst_encoder_pkg;

    localparam logic [2:0] CLS_TYPE_A = 3'b010;
    localparam logic [2:0] CLS_TYPE_B = 3'b001;
    localparam logic [2:0] CLS_NOP    = 3'b111;

    localparam logic [5:0] COMP_TYPE_A = 6'b111101;
    localparam logic [5:0] COMP_TYPE_B = 6'b111110;
    localparam logic [5:0] COMP_NOP    = 6'b000000;

    localparam int WORD_W    = 32;
    localparam int COMP_W    = 6;
    localparam int PAYLOAD_W = 28;
    localparam int ENTRY_W   = WORD_W + COMP_W;

    // {word[31:30], word[1:0]}
    typedef logic [3:0] field_t;

    typedef struct packed {
        logic       legal;
        field_t     field;
        logic [5:0] comp;
    } enc_t;

    // Illegal codes come back with the NOP encoding and legal cleared.
    function automatic enc_t encode_class(input logic [2:0] cls);
        enc_t enc;
        enc = '{legal: 1'b1, field: 4'b0000, comp: COMP_NOP};
        case (cls)
            CLS_TYPE_A: begin
                enc.field = 4'b0001;
                enc.comp  = COMP_TYPE_A;
            end
            CLS_TYPE_B: begin
                enc.field = 4'b0010;
                enc.comp  = COMP_TYPE_B;
            end
            CLS_NOP: begin
                enc.field = 4'b0000;
                enc.comp  = COMP_NOP;
            end
            default: enc.legal = 1'b0;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// Synchronous FIFO holding encoded entries; the caller gates push/pop with full/empty.
// Head data reads as zero while empty.
module inst_encoder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: storage is not reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata = (level == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: maps class code + payload to a 32-bit word and comp code, queued in a FIFO.
// Define INST_ENCODER_ILLEGAL_DROP_EN to count illegal codes without enqueueing them.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_inst,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          out_word,
    output logic [COMP_W-1:0]          out_comp,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           illegal_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    enc_t               enc;
    logic               accept;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    // A full FIFO refuses a push even when the same cycle pops.
    assign in_ready = (level != FULL_LEVEL);
    assign accept   = in_valid && in_ready && !rst;
    assign enc      = encode_class(in_inst);

`ifdef INST_ENCODER_ILLEGAL_DROP_EN
    assign push = accept && enc.legal;
`else
    assign push = accept;
`endif

    assign pop       = out_valid && out_ready;
    assign out_valid = (level != '0);
    assign wdata     = {enc.field[3:2], in_payload, enc.field[1:0], enc.comp};
    assign {out_word, out_comp} = rdata;

    inst_encoder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && !enc.legal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed pushes queue hand-computed entries,
// a negedge monitor pops and compares whenever the DUT hands an entry over.
module tb_inst_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
`ifdef INST_ENCODER_ILLEGAL_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_inst;
    logic [27:0] in_payload;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_comp;
    logic [2:0]  level;
    logic [1:0]  illegal_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [37:0] sb [$];
    logic [37:0] exp_e;
    bit          acc;

    inst_encoder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_comp    (out_comp),
        .level       (level),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one instruction for one cycle; queues the expected entry if it is accepted and kept.
    task automatic push(input string name, input logic [2:0] inst, input logic [27:0] payload,
                        input logic [31:0] w, input logic [5:0] c, input bit legal,
                        input bit exp_acc);
        in_valid   = 1'b1;
        in_inst    = inst;
        in_payload = payload;
        @(negedge clk);
        acc = in_ready;
        if (acc && (legal || !DROP)) sb.push_back({w, c});
        check({name, "_accept"}, acc, exp_acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got word %08h comp %02h, expected no entry", out_word, out_comp);
            end else begin
                exp_e = sb.pop_front();
                check("out_word", out_word, exp_e[37:6]);
                check("out_comp", out_comp, exp_e[5:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_inst    = 3'b000;
        in_payload = '0;
        out_ready  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_level", level, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_word", out_word, 0);
        check("rst_out_comp", out_comp, 0);
        check("rst_illegal_cnt", illegal_cnt, 0);
        step();

        // Streaming with the consumer always ready.
        out_ready = 1'b1;
        push("s1", 3'b010, 28'h0ABCDEF, 32'h02AF37BD, 6'b111101, 1'b1, 1'b1);
        push("s2", 3'b001, 28'h0000000, 32'h00000002, 6'b111110, 1'b1, 1'b1);
        push("s3", 3'b111, 28'hFFFFFFF, 32'h3FFFFFFC, 6'b000000, 1'b1, 1'b1);
        push("s4", 3'b010, 28'h8000001, 32'h20000005, 6'b111101, 1'b1, 1'b1);
        @(negedge clk);
        check("stream_level", level, 1);
        step();
        @(negedge clk);
        check("drained_level", level, 0);
        check("drained_valid", out_valid, 0);
        check("drained_word", out_word, 0);
        check("drained_comp", out_comp, 0);
        step();

        // Fill to DEPTH with the consumer stalled.
        out_ready = 1'b0;
        push("f1", 3'b010, 28'd1, 32'h00000005, 6'b111101, 1'b1, 1'b1);
        push("f2", 3'b001, 28'd2, 32'h0000000A, 6'b111110, 1'b1, 1'b1);
        push("f3", 3'b111, 28'd3, 32'h0000000C, 6'b000000, 1'b1, 1'b1);
        push("f4", 3'b010, 28'd4, 32'h00000011, 6'b111101, 1'b1, 1'b1);
        @(negedge clk);
        check("full_level", level, 4);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_head_stable", out_word, 32'h00000005);
        step();
        out_ready = 1'b1;
        push("f5_refused", 3'b001, 28'd5, 32'h00000016, 6'b111110, 1'b1, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        check("after_pop_level", level, 3);
        check("after_pop_in_ready", in_ready, 1);
        check("after_pop_head", out_word, 32'h0000000A);
        step();
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("fill_drained_level", level, 0);
        step();

        // Single illegal code with the consumer stalled.
        out_ready = 1'b0;
        push("ill1", 3'b100, 28'h1234567, 32'h048D159C, 6'b000000, 1'b0, 1'b1);
        @(negedge clk);
        check("ill1_cnt", illegal_cnt, 1);
        check("ill1_level", level, DROP ? 64'd0 : 64'd1);
        check("ill1_comp", out_comp, 0);
        check("ill1_word", out_word, DROP ? 64'd0 : 64'h048D159C);
        step();
        out_ready = 1'b1;
        step();
        step();

        // Counter saturation at 2'b11.
        push("ill2", 3'b000, 28'd0, 32'h0, 6'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("ill2_cnt", illegal_cnt, 2);
        step();
        push("ill3", 3'b011, 28'd0, 32'h0, 6'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("ill3_cnt", illegal_cnt, 3);
        step();
        push("ill4", 3'b101, 28'd0, 32'h0, 6'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("ill4_cnt_sat", illegal_cnt, 3);
        step();
        push("ill5", 3'b110, 28'd0, 32'h0, 6'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("ill5_cnt_sat", illegal_cnt, 3);
        step();
        step();
        @(negedge clk);
        check("ill_drained_level", level, 0);
        step();

        // Reset mid-stream discards queued entries.
        out_ready = 1'b0;
        push("r1", 3'b010, 28'd7, 32'h0000001D, 6'b111101, 1'b1, 1'b1);
        push("r2", 3'b001, 28'd8, 32'h00000022, 6'b111110, 1'b1, 1'b1);
        push("r3", 3'b111, 28'd9, 32'h00000024, 6'b000000, 1'b1, 1'b1);
        @(negedge clk);
        check("pre_rst_level", level, 3);
        step();
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_level", level, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_illegal_cnt", illegal_cnt, 0);
        check("mid_rst_out_word", out_word, 0);
        step();
        out_ready = 1'b1;
        push("post_rst", 3'b001, 28'h00000AB, 32'h000002AE, 6'b111110, 1'b1, 1'b1);
        step();
        step();
        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("final_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
